// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the transmit arbiter.
// Contents: the arbiter state enum, the default WIDTH_SIZE and NUM_REQ values,
// and a helper that steps a requester index forward around the ring.
package tx_arb_pkg;

  localparam int unsigned DEF_WIDTH_SIZE = 32;
  localparam int unsigned DEF_NUM_REQ    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // (base + off) wrapped into the range 0..n-1
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/tx_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req    - pending request vector, one bit per requester
//   rr_ptr - index with the highest priority this round
//   winner - first pending index found at or after rr_ptr (wrapping)
//   found  - high when any request is pending
module tx_rr_picker
  import tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       found
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Scan from the farthest offset back to rr_ptr so the nearest pending one wins
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req[IDX_W'(rr_wrap(32'(rr_ptr), 32'(k), NUM_REQ))]) begin
        winner = IDX_W'(rr_wrap(32'(rr_ptr), 32'(k), NUM_REQ));
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding one transmit path from NUM_REQ requesters.
// A winner is captured in IDLE when tx_ready is high, driven in ISSUE until
// tx_ready falls (acceptance), then held in WAIT until tx_ready rises again.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   req_valid/data/err/pf - per-requester frame request and payload
//   req_ack             - one-cycle acknowledge to the captured requester
//   tx_valid/data/err/pf - drive to the transmit path
//   tx_ready            - transmit-path idle flag, falls on acceptance
//   grant_id, busy      - current owner and activity flag
//   frame_cnt           - per-requester 16-bit saturating frame counts
//                         (only present when TX_ARB_CNT_EN is defined)
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned WIDTH_SIZE = DEF_WIDTH_SIZE,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_err,
  input  logic [NUM_REQ-1:0]            req_pf,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          tx_valid,
  output logic [WIDTH_SIZE-1:0]         tx_data,
  output logic                          tx_err,
  output logic                          tx_pf,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef TX_ARB_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]         frame_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_d;
  logic [NUM_REQ-1:0]     ack_d;
  logic                   tx_valid_d;
  logic [WIDTH_SIZE-1:0]  tx_data_d;
  logic                   tx_err_d;
  logic                   tx_pf_d;
  logic                   busy_d;
  logic [IDX_W-1:0]       pick_idx_c;
  logic                   pick_found_c;

  tx_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx_c),
    .found  (pick_found_c)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_id;
    ack_d      = '0;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    tx_err_d   = tx_err;
    tx_pf_d    = tx_pf;
    busy_d     = busy;

    case (state_q)
      IDLE: begin
        if (tx_ready && pick_found_c) begin
          state_d             = ISSUE;
          grant_d             = pick_idx_c;
          ack_d[pick_idx_c]   = 1'b1;
          tx_valid_d          = 1'b1;
          tx_data_d           = req_data[32'(pick_idx_c)*WIDTH_SIZE +: WIDTH_SIZE];
          tx_err_d            = req_err[pick_idx_c];
          tx_pf_d             = req_pf[pick_idx_c];
          busy_d              = 1'b1;
        end
      end
      ISSUE: begin
        // tx_ready low means the transmit path has taken the frame
        if (!tx_ready) begin
          state_d    = WAIT;
          tx_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (tx_ready) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = IDX_W'(rr_wrap(32'(grant_id), 32'd1, NUM_REQ));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_id <= '0;
      req_ack  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_err   <= 1'b0;
      tx_pf    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id <= grant_d;
      req_ack  <= ack_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      tx_err   <= tx_err_d;
      tx_pf    <= tx_pf_d;
      busy     <= busy_d;
    end
  end

`ifdef TX_ARB_CNT_EN
  localparam int unsigned CNT_W = 16;

  // Count accepted frames per requester, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (state_q == ISSUE && !tx_ready &&
                 frame_cnt[32'(grant_id)*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
      frame_cnt[32'(grant_id)*CNT_W +: CNT_W] <=
        frame_cnt[32'(grant_id)*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios followed by random
// frames, all checked against a rotation-order reference model.
module tb_tx_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_err;
  logic [N-1:0]     req_pf;
  logic [N-1:0]     req_ack;
  logic             tx_valid;
  logic [W-1:0]     tx_data;
  logic             tx_err;
  logic             tx_pf;
  logic             tx_ready;
  logic [IW-1:0]    grant_id;
  logic             busy;
`ifdef TX_ARB_CNT_EN
  logic [N*16-1:0]  frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;
  int unsigned model_cnt [N];

  tx_arbiter #(
    .WIDTH_SIZE (W),
    .NUM_REQ    (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_err   (req_err),
    .req_pf    (req_pf),
    .req_ack   (req_ack),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_err    (tx_err),
    .tx_pf     (tx_pf),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef TX_ARB_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First pending requester in rotation order starting at the model pointer
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < int'(N); k++)
      if (v[(model_ptr + k) % int'(N)]) return (model_ptr + k) % int'(N);
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_tx_valid"}, 64'(tx_valid), 64'(0));
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_ack"},      64'(req_ack),  64'(0));
  endtask

  task automatic check_cnt(input int w);
`ifdef TX_ARB_CNT_EN
    check("frame_cnt", 64'(frame_cnt[w*16 +: 16]), 64'(model_cnt[w]));
`else
    if (w < 0) $display("unused requester index");
`endif
  endtask

  // Hold tx_ready low in IDLE with some requests pending: nothing may be granted
  task automatic idle_blocked(input logic [N-1:0] v, input int cycles);
    req_valid = v;
    tx_ready  = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check_idle("blocked");
    end
  endtask

  // One full frame: request, capture, issue, accept, wait, release
  task automatic run_frame(input logic [N-1:0] v, input int hold_issue, input int hold_wait);
    logic [W-1:0] d [N];
    logic [N-1:0] e, p, one_hot;
    logic [W-1:0] exp_d;
    logic         exp_e, exp_p;
    int           w;
    w = pick(v);
    e = N'($urandom);
    p = N'($urandom);
    for (int i = 0; i < int'(N); i++) begin
      d[i] = $urandom;
      req_data[i*W +: W] = d[i];
    end
    req_err   = e;
    req_pf    = p;
    req_valid = v;
    tx_ready  = 1'b1;
    @(negedge clk);
    if (w < 0) begin
      check_idle("noreq");
      return;
    end
    exp_d = d[w];
    exp_e = e[w];
    exp_p = p[w];
    one_hot = '0;
    one_hot[w] = 1'b1;
    check("grant_ack",      64'(req_ack),  64'(one_hot));
    check("grant_tx_valid", 64'(tx_valid), 64'(1));
    check("grant_id",       64'(grant_id), 64'(w));
    check("grant_tx_data",  64'(tx_data),  64'(exp_d));
    check("grant_tx_err",   64'(tx_err),   64'(exp_e));
    check("grant_tx_pf",    64'(tx_pf),    64'(exp_p));
    check("grant_busy",     64'(busy),     64'(1));
    // Requester is free to change its inputs once acknowledged
    for (int i = 0; i < int'(N); i++) req_data[i*W +: W] = $urandom;
    req_err = ~e;
    req_pf  = ~p;
    repeat (hold_issue) begin
      @(negedge clk);
      check("issue_ack",      64'(req_ack),  64'(0));
      check("issue_tx_valid", 64'(tx_valid), 64'(1));
      check("issue_tx_data",  64'(tx_data),  64'(exp_d));
    end
    tx_ready = 1'b0;
    @(negedge clk);
    if (model_cnt[w] != 32'hFFFF) model_cnt[w]++;
    check("wait_tx_valid", 64'(tx_valid), 64'(0));
    check("wait_busy",     64'(busy),     64'(1));
    check("wait_ack",      64'(req_ack),  64'(0));
    check("wait_tx_data",  64'(tx_data),  64'(exp_d));
    check("wait_tx_err",   64'(tx_err),   64'(exp_e));
    check("wait_tx_pf",    64'(tx_pf),    64'(exp_p));
    check("wait_grant_id", 64'(grant_id), 64'(w));
    check_cnt(w);
    repeat (hold_wait) begin
      @(negedge clk);
      check("wait_hold_busy", 64'(busy),    64'(1));
      check("wait_hold_data", 64'(tx_data), 64'(exp_d));
    end
    req_valid = '0;
    tx_ready  = 1'b1;
    @(negedge clk);
    check_idle("release");
    model_ptr = (w + 1) % int'(N);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_err   = '0;
    req_pf    = '0;
    tx_ready  = 1'b1;
    for (int i = 0; i < int'(N); i++) model_cnt[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_tx_data",  64'(tx_data),  64'(0));
    check("rst_tx_err",   64'(tx_err),   64'(0));
    check("rst_tx_pf",    64'(tx_pf),    64'(0));
    check("rst_ack",      64'(req_ack),  64'(0));
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    reset = 1'b0;

    // All four requesting continuously: order 0,1,2,3,0
    repeat (5) run_frame(4'b1111, 1, 1);

    // Single requester 0
    run_frame(4'b0001, 2, 2);

    // Move pointer to 2, then 1010 grants 3 then 1, leaving pointer at 2
    run_frame(4'b0010, 0, 0);
    run_frame(4'b1010, 0, 1);
    run_frame(4'b1010, 1, 0);

    // tx_ready low in IDLE for 20 cycles, then a request withdrawn before grant
    idle_blocked(4'b1111, 20);
    idle_blocked(4'b0001, 2);
    run_frame(4'b1000, 0, 0);

    // Reset during WAIT of requester 2's frame
    run_frame(4'b0010, 0, 0);
    req_valid = 4'b0100;
    tx_ready  = 1'b1;
    @(negedge clk);
    check("pre_rst_grant", 64'(grant_id), 64'(2));
    tx_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_busy",     64'(busy),     64'(0));
    check("arst_tx_data",  64'(tx_data),  64'(0));
    check("arst_tx_err",   64'(tx_err),   64'(0));
    check("arst_tx_pf",    64'(tx_pf),    64'(0));
    check("arst_tx_valid", 64'(tx_valid), 64'(0));
    check("arst_ack",      64'(req_ack),  64'(0));
    check("arst_grant_id", 64'(grant_id), 64'(0));
    @(negedge clk);
    check_idle("in_rst");
    reset     = 1'b0;
    req_valid = '0;
    tx_ready  = 1'b1;
    model_ptr = 0;
    for (int i = 0; i < int'(N); i++) model_cnt[i] = 0;
    run_frame(4'b1111, 0, 0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idle_blocked(N'($urandom), $urandom_range(1, 3));
      run_frame(N'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
